// File: rtl/data_if_pkg.sv
// Shared types and helpers for the data-memory initiator: access sizes,
// FSM states and the 8-bit (two-word) byte-enable generator.
package data_if_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    RESP  = 3'd5
  } state_e;

  // Encoding 3 is illegal on the command port and behaves as a word access.
  function automatic size_e size_norm(logic [1:0] raw);
    size_e s;
    case (raw)
      2'd0:    s = SZ_BYTE;
      2'd1:    s = SZ_HALF;
      default: s = SZ_WORD;
    endcase
    return s;
  endfunction

  // Bits [3:0] are lanes of the first word, bits [7:4] of the following word.
  function automatic logic [7:0] be_gen(size_e size, logic [1:0] offset);
    logic [7:0] mask;
    case (size)
      SZ_BYTE: mask = 8'h01;
      SZ_HALF: mask = 8'h03;
      default: mask = 8'h0F;
    endcase
    return mask << offset;
  endfunction

endpackage

// File: rtl/data_req_master_if.sv
// Command, response and data-bus signals of the data-memory initiator.
// Names are from the initiator's view: *_i are driven into it, *_o out of it.
interface data_req_master_if;
  // cmd: transfer when cmd_valid_i && cmd_ready_o on a rising edge; bus: req is
  // held with stable addr/be/we/wdata until gnt; rsp: single pulse, no backpressure.
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [1:0]  cmd_size_i;
  logic        cmd_signed_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_size_i, cmd_signed_i, cmd_addr_i, cmd_wdata_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_size_i, cmd_signed_i, cmd_addr_i, cmd_wdata_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );
endinterface

// File: rtl/data_rdata_align.sv
// Extracts a load result from the two captured bus words: shift down by the
// byte offset, keep the access width, then sign- or zero-extend.
module data_rdata_align
  import data_if_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        signed_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = 32'(data_i >> {off_i, 3'b000});

  always_comb begin
    rdata_o = shifted;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_req_master.sv
// Data-memory initiator: turns one byte-addressed load/store command into one
// or two word-aligned req/gnt/rvalid transactions and returns one response.
module data_req_master
  import data_if_pkg::*;
#(
  parameter int RVALID_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  data_req_master_if.master bus,
  output state_e            dbg_state_o
);

  localparam logic [15:0] TMO_LAST = 16'(RVALID_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        signed_q, signed_d;
  size_e       size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [29:0] waddr_q, waddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  be_q, be_d;
  logic        split_q, split_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;
  logic [15:0] cnt_q, cnt_d;

  size_e       cmd_size;
  logic [7:0]  cmd_be;
  logic        tmo_hit;
  logic [31:0] align_rdata;

  assign cmd_size = size_norm(bus.cmd_size_i);
  assign cmd_be   = be_gen(cmd_size, bus.cmd_addr_i[1:0]);
  assign tmo_hit  = (RVALID_TIMEOUT != 0) && (cnt_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    signed_d = signed_q;
    size_d   = size_q;
    off_d    = off_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    split_d  = split_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          we_d     = bus.cmd_we_i;
          signed_d = bus.cmd_signed_i;
          size_d   = cmd_size;
          off_d    = bus.cmd_addr_i[1:0];
          waddr_d  = bus.cmd_addr_i[31:2];
          wdata_d  = bus.cmd_we_i ? ({32'b0, bus.cmd_wdata_i} << {bus.cmd_addr_i[1:0], 3'b000})
                                  : 64'b0;
          be_d     = cmd_be;
          split_d  = |cmd_be[7:4];
          lo_d     = 32'b0;
          hi_d     = 32'b0;
          err_d    = 1'b0;
          tmo_d    = 1'b0;
          state_d  = REQ1;
        end
      end
      REQ1, WAIT1: begin
        if ((state_q == WAIT1 || bus.data_gnt_i) && bus.data_rvalid_i) begin
          lo_d    = bus.data_rdata_i;
          err_d   = err_q | bus.data_err_i;
          state_d = split_q ? REQ2 : RESP;
        end else if (state_q == REQ1 && bus.data_gnt_i) begin
          cnt_d   = 16'd0;
          state_d = WAIT1;
        end else if (state_q == WAIT1) begin
          // No rvalid within the window: give up, including any pending txn2.
          if (tmo_hit) begin
            err_d   = 1'b1;
            tmo_d   = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      REQ2, WAIT2: begin
        if ((state_q == WAIT2 || bus.data_gnt_i) && bus.data_rvalid_i) begin
          hi_d    = bus.data_rdata_i;
          err_d   = err_q | bus.data_err_i;
          state_d = RESP;
        end else if (state_q == REQ2 && bus.data_gnt_i) begin
          cnt_d   = 16'd0;
          state_d = WAIT2;
        end else if (state_q == WAIT2) begin
          if (tmo_hit) begin
            err_d   = 1'b1;
            tmo_d   = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_BYTE;
      off_q    <= 2'b0;
      waddr_q  <= 30'b0;
      wdata_q  <= 64'b0;
      be_q     <= 8'b0;
      split_q  <= 1'b0;
      lo_q     <= 32'b0;
      hi_q     <= 32'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= 16'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      signed_q <= signed_d;
      size_q   <= size_d;
      off_q    <= off_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      split_q  <= split_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  data_rdata_align u_align (
    .data_i   ({hi_q, lo_q}),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .rdata_o  (align_rdata)
  );

  // Bus outputs decode purely from state and registered command fields.
  assign bus.cmd_ready_o  = (state_q == IDLE);
  assign bus.data_req_o   = (state_q == REQ1) || (state_q == REQ2);
  assign bus.data_we_o    = bus.data_req_o & we_q;
  assign bus.data_addr_o  = (state_q == REQ1) ? {waddr_q, 2'b00} :
                            (state_q == REQ2) ? {waddr_q + 30'd1, 2'b00} : 32'b0;
  assign bus.data_be_o    = (state_q == REQ1) ? be_q[3:0] :
                            (state_q == REQ2) ? be_q[7:4] : 4'b0;
  assign bus.data_wdata_o = (state_q == REQ1) ? wdata_q[31:0] :
                            (state_q == REQ2) ? wdata_q[63:32] : 32'b0;
  assign bus.rsp_valid_o  = (state_q == RESP);
  assign bus.rsp_err_o    = (state_q == RESP) & err_q;
  assign bus.rsp_rdata_o  = ((state_q == RESP) && !we_q && !tmo_q) ? align_rdata : 32'b0;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_data_req_master.sv
// Directed bench for data_req_master: drives commands, plays a simple bus
// responder cycle by cycle and compares bus and response against fixed values.
module tb_data_req_master;
  import data_if_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_e dbg_state;
  int     checks = 0;
  int     failures = 0;

  always #5 clk = ~clk;

  data_req_master_if bus ();

  data_req_master #(.RVALID_TIMEOUT(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_we_i     = we;
    bus.cmd_size_i   = size;
    bus.cmd_signed_i = sgn;
    bus.cmd_addr_i   = addr;
    bus.cmd_wdata_i  = wdata;
    step();
    bus.cmd_valid_i  = 1'b0;
  endtask

  // Waits (bounded) for req, samples the bus, grants one cycle later together
  // with rvalid, and returns one cycle after the grant.
  task automatic bus_txn(input logic [31:0] rdata, input logic err,
                         output logic [31:0] addr, output logic [3:0] be,
                         output logic [31:0] wdata, output logic we, output logic seen);
    int n;
    n = 0;
    while (bus.data_req_o !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    seen  = (bus.data_req_o === 1'b1);
    addr  = bus.data_addr_o;
    be    = bus.data_be_o;
    wdata = bus.data_wdata_o;
    we    = bus.data_we_o;
    step();
    bus.data_gnt_i    = 1'b1;
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i  = rdata;
    bus.data_err_i    = err;
    step();
    bus.data_gnt_i    = 1'b0;
    bus.data_rvalid_i = 1'b0;
    bus.data_rdata_i  = 32'b0;
    bus.data_err_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.cmd_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.cmd_ready_o); end
    checks++; if ({bus.data_req_o, bus.data_we_o, bus.rsp_valid_o, bus.rsp_err_o} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b want=0000", {bus.data_req_o, bus.data_we_o, bus.rsp_valid_o, bus.rsp_err_o}); end
    checks++; if ({bus.data_be_o, bus.data_addr_o, bus.data_wdata_o, bus.rsp_rdata_o} !== 100'b0) begin
      failures++; $display("FAIL reset_buses got=%h want=0", {bus.data_be_o, bus.data_addr_o, bus.data_wdata_o, bus.rsp_rdata_o}); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_word_store();
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we, seen;
    send_cmd(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    checks++; if (bus.data_req_o !== 1'b1) begin failures++; $display("FAIL wst_req_cycle1 got=%b want=1", bus.data_req_o); end
    bus_txn(32'h0, 1'b0, a, be, wd, we, seen);
    checks++; if ({a, be, wd, we} !== {32'h100, 4'b1111, 32'hDEADBEEF, 1'b1}) begin
      failures++; $display("FAIL wst_bus got=%h/%b/%h/%b want=00000100/1111/deadbeef/1", a, be, wd, we); end
    checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o} !== {1'b1, 1'b0, 32'h0}) begin
      failures++; $display("FAIL wst_rsp_cycle3 got=%b/%b/%h want=1/0/00000000", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o); end
    step();
    checks++; if ({bus.rsp_valid_o, bus.cmd_ready_o} !== 2'b01) begin
      failures++; $display("FAIL wst_after got=%b want=01", {bus.rsp_valid_o, bus.cmd_ready_o}); end
  endtask

  task automatic test_byte_load();
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we, seen;
    logic [31:0] exp_r [2];
    exp_r[0] = 32'hFFFF_FF80;
    exp_r[1] = 32'h0000_0080;
    for (int i = 0; i < 2; i++) begin
      send_cmd(1'b0, 2'd0, (i == 0), 32'h0000_0103, 32'h0);
      bus_txn(32'h8033_2211, 1'b0, a, be, wd, we, seen);
      checks++; if ({a, be, we} !== {32'h100, 4'b1000, 1'b0}) begin
        failures++; $display("FAIL bld_bus%0d got=%h/%b/%b want=00000100/1000/0", i, a, be, we); end
      checks++; if ({bus.rsp_valid_o, bus.rsp_rdata_o} !== {1'b1, exp_r[i]}) begin
        failures++; $display("FAIL bld_rdata%0d got=%b/%h want=1/%h", i, bus.rsp_valid_o, bus.rsp_rdata_o, exp_r[i]); end
      step();
    end
  endtask

  task automatic test_split_load();
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we, seen;
    send_cmd(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0);
    bus_txn(32'h4433_2211, 1'b0, a, be, wd, we, seen);
    checks++; if ({a, be} !== {32'h100, 4'b1100}) begin failures++; $display("FAIL sld_txn1 got=%h/%b want=00000100/1100", a, be); end
    bus_txn(32'h8877_6655, 1'b0, a, be, wd, we, seen);
    checks++; if ({seen, a, be} !== {1'b1, 32'h104, 4'b0011}) begin
      failures++; $display("FAIL sld_txn2 got=%b/%h/%b want=1/00000104/0011", seen, a, be); end
    checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o} !== {1'b1, 1'b0, 32'h6655_4433}) begin
      failures++; $display("FAIL sld_rsp_cycle5 got=%b/%b/%h want=1/0/66554433", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o); end
    step();
  endtask

  task automatic test_split_store();
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we, seen;
    send_cmd(1'b1, 2'd1, 1'b0, 32'h0000_0103, 32'h0000_BBAA);
    bus_txn(32'h0, 1'b0, a, be, wd, we, seen);
    checks++; if ({a, be, wd, we} !== {32'h100, 4'b1000, 32'hAA00_0000, 1'b1}) begin
      failures++; $display("FAIL sst_txn1 got=%h/%b/%h/%b want=00000100/1000/aa000000/1", a, be, wd, we); end
    bus_txn(32'h0, 1'b0, a, be, wd, we, seen);
    checks++; if ({a, be, wd, we} !== {32'h104, 4'b0001, 32'h0000_00BB, 1'b1}) begin
      failures++; $display("FAIL sst_txn2 got=%h/%b/%h/%b want=00000104/0001/000000bb/1", a, be, wd, we); end
    checks++; if ({bus.rsp_valid_o, bus.rsp_rdata_o} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL sst_rsp got=%b/%h want=1/00000000", bus.rsp_valid_o, bus.rsp_rdata_o); end
    step();
  endtask

  task automatic test_stall();
    send_cmd(1'b0, 2'd2, 1'b1, 32'h0000_0200, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.data_req_o, bus.data_addr_o, bus.data_be_o} !== {1'b1, 32'h200, 4'b1111}) begin
        failures++; $display("FAIL stall_hold%0d got=%b/%h/%b want=1/00000200/1111", i, bus.data_req_o, bus.data_addr_o, bus.data_be_o); end
      step();
    end
    bus.data_gnt_i = 1'b1;
    step();
    bus.data_gnt_i = 1'b0;
    checks++; if (bus.data_req_o !== 1'b0) begin failures++; $display("FAIL stall_req_drop got=%b want=0", bus.data_req_o); end
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i  = 32'hCAFE_F00D;
    step();
    bus.data_rvalid_i = 1'b0;
    bus.data_rdata_i  = 32'h0;
    checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL stall_rsp got=%b/%b/%h want=1/0/cafef00d", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o); end
    step();
  endtask

  task automatic test_timeout();
    int pulses;
    send_cmd(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0);
    step();
    bus.data_gnt_i = 1'b1;
    step();
    bus.data_gnt_i = 1'b0;
    repeat (15) step();
    checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b want=0", bus.rsp_valid_o); end
    step();
    checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o} !== {1'b1, 1'b1, 32'h0}) begin
      failures++; $display("FAIL tmo_rsp got=%b/%b/%h want=1/1/00000000", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o); end
    step();
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i  = 32'hFFFF_FFFF;
    step();
    bus.data_rvalid_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.rsp_valid_o === 1'b1 || bus.cmd_ready_o !== 1'b1) pulses++;
      step();
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL tmo_late_rvalid got=%0d want=0", pulses); end
  endtask

  task automatic test_err_split();
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we, seen;
    send_cmd(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0);
    bus_txn(32'h4433_2211, 1'b1, a, be, wd, we, seen);
    checks++; if ({a, be} !== {32'h100, 4'b1110}) begin failures++; $display("FAIL err_txn1 got=%h/%b want=00000100/1110", a, be); end
    bus_txn(32'h8877_6655, 1'b0, a, be, wd, we, seen);
    checks++; if ({seen, a, be} !== {1'b1, 32'h104, 4'b0001}) begin
      failures++; $display("FAIL err_txn2 got=%b/%h/%b want=1/00000104/0001", seen, a, be); end
    checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o} !== {1'b1, 1'b1, 32'h5544_3322}) begin
      failures++; $display("FAIL err_rsp got=%b/%b/%h want=1/1/55443322", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we, seen;
    send_cmd(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0);
    bus_txn(32'h1111_2222, 1'b0, a, be, wd, we, seen);
    checks++; if ({bus.rsp_valid_o, bus.cmd_ready_o, bus.rsp_rdata_o} !== {1'b1, 1'b0, 32'h1111_2222}) begin
      failures++; $display("FAIL b2b_rsp1 got=%b/%b/%h want=1/0/11112222", bus.rsp_valid_o, bus.cmd_ready_o, bus.rsp_rdata_o); end
    step();
    checks++; if (bus.cmd_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_cycle4 got=%b want=1", bus.cmd_ready_o); end
    send_cmd(1'b0, 2'd2, 1'b0, 32'h0000_0504, 32'h0);
    checks++; if ({bus.data_req_o, bus.data_addr_o} !== {1'b1, 32'h504}) begin
      failures++; $display("FAIL b2b_req2 got=%b/%h want=1/00000504", bus.data_req_o, bus.data_addr_o); end
    bus_txn(32'h3333_4444, 1'b0, a, be, wd, we, seen);
    checks++; if ({bus.rsp_valid_o, bus.rsp_rdata_o} !== {1'b1, 32'h3333_4444}) begin
      failures++; $display("FAIL b2b_rsp2 got=%b/%h want=1/33334444", bus.rsp_valid_o, bus.rsp_rdata_o); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we, seen;
    int          pulses;
    send_cmd(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0);
    rst = 1'b1;
    #1;
    checks++; if ({bus.data_req_o, bus.cmd_ready_o} !== 2'b01) begin
      failures++; $display("FAIL rst_async got=%b want=01", {bus.data_req_o, bus.cmd_ready_o}); end
    step();
    rst = 1'b0;
    step();
    send_cmd(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0);
    bus_txn(32'h4433_2211, 1'b0, a, be, wd, we, seen);
    bus.data_gnt_i = 1'b1;
    step();
    bus.data_gnt_i = 1'b0;
    checks++; if (dbg_state !== WAIT2) begin failures++; $display("FAIL rst_reach_wait2 got=%0d want=%0d", dbg_state, WAIT2); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({bus.data_req_o, bus.cmd_ready_o} !== 2'b01) begin
      failures++; $display("FAIL rst_wait2_after got=%b want=01", {bus.data_req_o, bus.cmd_ready_o}); end
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i  = 32'h8877_6655;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.data_rvalid_i = 1'b0;
      if (bus.rsp_valid_o === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_no_rsp got=%0d want=0", pulses); end
  endtask

  initial begin
    rst               = 1'b1;
    bus.cmd_valid_i   = 1'b0;
    bus.cmd_we_i      = 1'b0;
    bus.cmd_size_i    = 2'd0;
    bus.cmd_signed_i  = 1'b0;
    bus.cmd_addr_i    = 32'h0;
    bus.cmd_wdata_i   = 32'h0;
    bus.data_gnt_i    = 1'b0;
    bus.data_rvalid_i = 1'b0;
    bus.data_rdata_i  = 32'h0;
    bus.data_err_i    = 1'b0;
    test_reset();
    test_word_store();
    test_byte_load();
    test_split_load();
    test_split_store();
    test_stall();
    test_timeout();
    test_err_split();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_req_master.md
# data_req_master

Initiator side of the core data-memory interface (req/gnt/rvalid, byte enables). Accepts byte-addressed load/store commands from a simple valid/ready command port, converts them into one or two word-aligned bus transactions with byte enables, and returns a single aligned, size-masked and sign/zero-extended response. Drives the verification data-memory responder in contract-synthesis testbenches, and any other responder on the same interface.

## Interface
- RVALID_TIMEOUT, 16: max cycles spent waiting for data_rvalid_i after grant; 0 disables the timeout.
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when both cmd_valid_i and cmd_ready_o are high
- cmd_we_i  in  1  1 = store, 0 = load
- cmd_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
- cmd_signed_i  in  1  sign-extend load result
- cmd_addr_i  in  32  byte address, any alignment
- cmd_wdata_i  in  32  store data, LSB-aligned
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure
- rsp_rdata_o  out  32  load result; 0 for stores
- rsp_err_o  out  1  bus error or timeout
- data_req_o  out  1  bus request
- data_gnt_i  in  1  grant
- data_rvalid_i  in  1  response valid
- data_we_o  out  1  write enable
- data_be_o  out  4  be[k] selects byte at data_addr_o+k, carried on wdata/rdata[8k+7:8k]
- data_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- data_wdata_o  out  32  lane-shifted store data
- data_rdata_i  in  32  read data
- data_err_i  in  1  error, qualified by data_rvalid_i

## Operation
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- IDLE: cmd_ready_o = 1. On accept, register the command, compute offset = addr[1:0] and nbytes = 1/2/4, set split = (offset + nbytes > 4), then go to REQ1.
- REQ1/REQ2: data_req_o = 1. addr, be, we and wdata are held stable until data_gnt_i.
  - Txn1 be = (mask << offset)[3:0].
  - Txn2 (split only): address + 4, be = (mask << offset)[7:4], where mask = 2^nbytes − 1.
  - wdata = ({32'b0,wdata} << 8·offset), low or high word respectively.
- On grant, go to WAIT1/WAIT2. data_rvalid_i is accepted in the grant cycle itself; in that case the WAIT state is skipped.
- On rvalid: capture rdata into the low word (txn1) or high word (txn2), and OR data_err_i into a sticky error bit. Then go to REQ2 if split and txn1 just finished; otherwise go to RESP. An error on txn1 does not cancel txn2.
- RESP: rsp_valid_o = 1.
  - Loads: rsp_rdata_o = ({hi,lo} >> 8·offset), masked to nbytes, then sign- or zero-extended per cmd_signed_i.
  - Stores: rsp_rdata_o = 0.
  - Next state is IDLE.
- Timeout: a counter resets on entry to WAIT1/WAIT2. When it reaches RVALID_TIMEOUT, go to RESP with rsp_err_o = 1 and rdata = 0. A split stops at that point. Late rvalids arriving in IDLE are ignored.

## Timing
- Reset values: cmd_ready_o = 1; data_req_o, data_we_o, rsp_valid_o, rsp_err_o = 0; data_be_o = 0; data_addr_o, data_wdata_o, rsp_rdata_o = 0; state = IDLE.
- Reset mid-transaction aborts it immediately: data_req_o falls asynchronously and no response is produced.
- All outputs are registered or decoded from state; there is no combinational path from cmd_* to data_*.
- Latency with zero-wait responder (gnt and rvalid together, one cycle after req):
  - Accept at cycle 0, req at cycle 1, gnt+rvalid at cycle 2, rsp_valid at cycle 3.
  - A split command adds 2 cycles.
  - Back-to-back throughput is one command per 4 cycles (aligned).
- data_req_o drops the cycle after grant. It is never withdrawn before grant.

## Structure
- Shared package data_if_pkg: size_e enum (SZ_BYTE/SZ_HALF/SZ_WORD), state_e, function be_gen(size, offset) returning 8-bit mask.
- Sub-module data_rdata_align: combinational shift/mask/extend of {hi,lo} by offset, size and signed.

## Test plan
- Aligned word store: addr 0x100, data 0xDEADBEEF.
  - data_req_o at cycle 1 with be = 1111, addr 0x100, wdata 0xDEADBEEF.
  - rsp_valid_o at cycle 3, err = 0.
- Byte load at 0x103 with memory byte 0x80:
  - Bus shows be = 1000, addr 0x100.
  - Signed load returns 0xFFFFFF80; unsigned load returns 0x00000080.
- Misaligned word load at 0x102, with mem[0x100] = 0x44332211 and mem[0x104] = 0x88776655:
  - Txn1 addr 0x100, be = 1100; txn2 addr 0x104, be = 0011.
  - rsp_rdata_o = 0x66554433 at cycle 5.
- Misaligned half store at 0x103, data 0xBBAA:
  - Txn1 addr 0x100, be = 1000, wdata[31:24] = 0xAA.
  - Txn2 addr 0x104, be = 0001, wdata[7:0] = 0xBB.
- Stall and timeout:
  - gnt held low 3 cycles: req/addr/be/wdata stay stable.
  - rvalid never arrives, RVALID_TIMEOUT = 16: rsp_err_o = 1 and rdata = 0 after 16 WAIT cycles.
- Error and reset:
  - data_err_i on txn1 of a split: txn2 is still issued and rsp_err_o = 1.
  - rst_i pulsed during WAIT2: data_req_o = 0 and cmd_ready_o = 1 after release, with no rsp_valid_o.
